// File: rtl/axi_stream_extract_header.sv
// Strips a 1-4 byte header from each 32-bit AXI-Stream packet and re-aligns the payload.
// Optional AXIS_EXTRACT_ERR_EN adds err_short, a one-cycle pulse on a truncated header.
module axi_stream_extract_header #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              valid_in,
   input  logic [DATA_W-1:0] data_in,
   input  logic [3:0]        keep_in,
   input  logic              last_in,
   output logic              ready_in,
   input  logic [1:0]        byte_remove_cnt,
   output logic              valid_header,
   output logic [DATA_W-1:0] data_header,
   output logic [3:0]        keep_header,
   input  logic              ready_header,
   output logic              valid_out,
   output logic [DATA_W-1:0] data_out,
   output logic [3:0]        keep_out,
   output logic              last_out,
   input  logic              ready_out
`ifdef AXIS_EXTRACT_ERR_EN
   ,
   output logic              err_short
`endif
);

   if (DATA_W != 32) begin : g_bad_width
      $error("axi_stream_extract_header: DATA_W must be 32");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_STREAM,
      S_FLUSH
   } state_e;

   function automatic logic [2:0] keep_to_cnt(input logic [3:0] keep);
      case (keep)
         4'b1000: return 3'd1;
         4'b1100: return 3'd2;
         4'b1110: return 3'd3;
         4'b1111: return 3'd4;
         default: return 3'd1;
      endcase
   endfunction

   function automatic logic [3:0] cnt_to_keep(input logic [2:0] n);
      case (n)
         3'd0:    return 4'b0000;
         3'd1:    return 4'b1000;
         3'd2:    return 4'b1100;
         3'd3:    return 4'b1110;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] byte_mask(input logic [3:0] keep);
      return {{8{keep[3]}}, {8{keep[2]}}, {8{keep[1]}}, {8{keep[0]}}};
   endfunction

   state_e      state_q, state_d;
   logic        hdr_valid_q, hdr_valid_d;
   logic [31:0] hdr_data_q, hdr_data_d;
   logic [3:0]  hdr_keep_q, hdr_keep_d;
   logic [31:0] res_q, res_d;
   logic [2:0]  res_cnt_q, res_cnt_d;

   logic [2:0]  h_first, h_cur, k_in, hdr_cnt, t_cnt, tail_first, tail_cur;
   logic [31:0] shift_first, shift_cur, merged;

   // Residual bytes are kept left-aligned; in STREAM res_cnt_q is R, so H is implied.
   assign h_first     = {1'b0, byte_remove_cnt} + 3'd1;
   assign h_cur       = 3'd4 - res_cnt_q;
   assign k_in        = last_in ? keep_to_cnt(keep_in) : 3'd4;
   assign hdr_cnt     = (k_in < h_first) ? k_in : h_first;
   assign t_cnt       = res_cnt_q + k_in;
   assign tail_first  = k_in - h_first;
   assign tail_cur    = k_in - h_cur;
   assign shift_first = data_in << {h_first, 3'b000};
   assign shift_cur   = data_in << {h_cur, 3'b000};
   assign merged      = res_q | (data_in >> {res_cnt_q, 3'b000});

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d     = state_q;
      hdr_valid_d = hdr_valid_q;
      hdr_data_d  = hdr_data_q;
      hdr_keep_d  = hdr_keep_q;
      res_d       = res_q;
      res_cnt_d   = res_cnt_q;
      ready_in    = 1'b0;
      valid_out   = 1'b0;
      data_out    = '0;
      keep_out    = 4'b0000;
      last_out    = 1'b0;

      if (hdr_valid_q && ready_header) begin
         hdr_valid_d = 1'b0;
      end

      unique case (state_q)
         S_IDLE: begin
            ready_in = ~hdr_valid_q;
            if (valid_in && !hdr_valid_q) begin
               hdr_valid_d = 1'b1;
               hdr_keep_d  = cnt_to_keep(hdr_cnt);
               hdr_data_d  = data_in & byte_mask(cnt_to_keep(hdr_cnt));
               if (!last_in) begin
                  res_d     = shift_first;
                  res_cnt_d = 3'd4 - h_first;
                  state_d   = S_STREAM;
               end else if (k_in > h_first) begin
                  res_d     = shift_first & byte_mask(cnt_to_keep(tail_first));
                  res_cnt_d = tail_first;
                  state_d   = S_FLUSH;
               end
            end
         end

         S_STREAM: begin
            ready_in  = ready_out;
            valid_out = valid_in;
            if (last_in && (t_cnt <= 3'd4)) begin
               keep_out = cnt_to_keep(t_cnt);
               data_out = merged & byte_mask(cnt_to_keep(t_cnt));
               last_out = 1'b1;
            end else begin
               keep_out = 4'b1111;
               data_out = merged;
            end
            if (valid_in && ready_out) begin
               if (!last_in) begin
                  res_d = shift_cur;
               end else if (t_cnt <= 3'd4) begin
                  res_d     = '0;
                  res_cnt_d = 3'd0;
                  state_d   = S_IDLE;
               end else begin
                  res_d     = shift_cur & byte_mask(cnt_to_keep(tail_cur));
                  res_cnt_d = tail_cur;
                  state_d   = S_FLUSH;
               end
            end
         end

         S_FLUSH: begin
            valid_out = 1'b1;
            data_out  = res_q;
            keep_out  = cnt_to_keep(res_cnt_q);
            last_out  = 1'b1;
            if (ready_out) begin
               res_d     = '0;
               res_cnt_d = 3'd0;
               state_d   = S_IDLE;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= S_IDLE;
         hdr_valid_q <= 1'b0;
         hdr_data_q  <= '0;
         hdr_keep_q  <= 4'b0000;
         res_q       <= '0;
         res_cnt_q   <= 3'd0;
      end else begin
         state_q     <= state_d;
         hdr_valid_q <= hdr_valid_d;
         hdr_data_q  <= hdr_data_d;
         hdr_keep_q  <= hdr_keep_d;
         res_q       <= res_d;
         res_cnt_q   <= res_cnt_d;
      end
   end

   assign valid_header = hdr_valid_q;
   assign data_header  = hdr_data_q;
   assign keep_header  = hdr_keep_q;

`ifdef AXIS_EXTRACT_ERR_EN
   logic err_q, err_d;

   assign err_d = (state_q == S_IDLE) && valid_in && !hdr_valid_q && last_in && (k_in < h_first);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err_short = err_q;
`endif

endmodule

// File: tb/tb_axi_stream_extract_header.sv
// Scoreboard bench for axi_stream_extract_header: a byte-level packet model predicts
// header and payload beats; a negedge monitor compares whatever the DUT hands over.
`timescale 1ns/1ps
module tb_axi_stream_extract_header;

   logic        clk = 1'b0;
   logic        rstn;
   logic        valid_in;
   logic [31:0] data_in;
   logic [3:0]  keep_in;
   logic        last_in;
   logic        ready_in;
   logic [1:0]  byte_remove_cnt;
   logic        valid_header;
   logic [31:0] data_header;
   logic [3:0]  keep_header;
   logic        ready_header;
   logic        valid_out;
   logic [31:0] data_out;
   logic [3:0]  keep_out;
   logic        last_out;
   logic        ready_out;
`ifdef AXIS_EXTRACT_ERR_EN
   logic        err_short;
`endif

   always #5 clk = ~clk;

   axi_stream_extract_header #(.DATA_W(32)) dut (
      .clk             (clk),
      .rstn            (rstn),
      .valid_in        (valid_in),
      .data_in         (data_in),
      .keep_in         (keep_in),
      .last_in         (last_in),
      .ready_in        (ready_in),
      .byte_remove_cnt (byte_remove_cnt),
      .valid_header    (valid_header),
      .data_header     (data_header),
      .keep_header     (keep_header),
      .ready_header    (ready_header),
      .valid_out       (valid_out),
      .data_out        (data_out),
      .keep_out        (keep_out),
      .last_out        (last_out),
      .ready_out       (ready_out)
`ifdef AXIS_EXTRACT_ERR_EN
      ,
      .err_short       (err_short)
`endif
   );

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  keep;
      logic        last;
   } beat_t;

   beat_t       exp_hdr[$];
   beat_t       exp_pay[$];
   logic [31:0] pkt_data[$];
   logic [3:0]  pkt_keep[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          err_exp  = 0;
   int          err_seen = 0;
   bit          rand_en  = 1'b0;
   bit          gap_en   = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   task automatic report_fail(input string name, input int act, input int req);
      n_checks++;
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
   endtask

   task automatic finish_test();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   endtask

   // Bytes carried by a last beat; non-last beats always carry four.
   function automatic int keep_bytes(input logic [3:0] k);
      case (k)
         4'b1000: return 1;
         4'b1100: return 2;
         4'b1110: return 3;
         4'b1111: return 4;
         default: return 1;
      endcase
   endfunction

   function automatic logic [3:0] lead_keep(input int n);
      logic [3:0] m;
      m = '0;
      for (int j = 0; j < n; j++) m[3-j] = 1'b1;
      return m;
   endfunction

   // Model: flatten the packet to bytes, the first H form the header, the rest repack by fours.
   task automatic push_expected(input int cnt);
      logic [7:0]  bytes[$];
      logic [31:0] d;
      beat_t       b;
      int          h, k0, hn, nb;
      h  = cnt + 1;
      k0 = 0;
      for (int i = 0; i < pkt_data.size(); i++) begin
         nb = (i == pkt_data.size() - 1) ? keep_bytes(pkt_keep[i]) : 4;
         if (i == 0) k0 = nb;
         d = pkt_data[i];
         for (int j = 0; j < nb; j++) bytes.push_back(d[31-8*j -: 8]);
      end
      hn = (k0 < h) ? k0 : h;
      d  = '0;
      for (int j = 0; j < hn; j++) d[31-8*j -: 8] = bytes[j];
      b = '{data: d, keep: lead_keep(hn), last: 1'b0};
      exp_hdr.push_back(b);
      if (pkt_data.size() == 1 && k0 < h) err_exp++;
      for (int p = h; p < bytes.size(); p += 4) begin
         d  = '0;
         nb = (bytes.size() - p > 4) ? 4 : bytes.size() - p;
         for (int j = 0; j < nb; j++) d[31-8*j -: 8] = bytes[p+j];
         b = '{data: d, keep: lead_keep(nb), last: (p + 4 >= bytes.size())};
         exp_pay.push_back(b);
      end
   endtask

   // Holds the beat until the DUT shows ready at a negedge; returns just after the accepting edge.
   task automatic drive_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
      int waited;
      waited   = 0;
      valid_in = 1'b1;
      data_in  = d;
      keep_in  = k;
      last_in  = l;
      @(negedge clk);
      while (!ready_in) begin
         waited++;
         if (waited > 500) begin
            report_fail("accept_timeout", waited, 500);
            finish_test();
         end
         @(negedge clk);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send_packet(input int cnt);
      push_expected(cnt);
      byte_remove_cnt = 2'(cnt);
      for (int i = 0; i < pkt_data.size(); i++) begin
         drive_beat(pkt_data[i], pkt_keep[i], i == pkt_data.size() - 1);
         byte_remove_cnt = 2'($urandom);
         if (gap_en && $urandom_range(0, 3) == 0) begin
            valid_in = 1'b0;
            data_in  = $urandom;
            keep_in  = 4'($urandom);
            last_in  = 1'($urandom);
            @(posedge clk);
            #1;
         end
      end
      valid_in = 1'b0;
      last_in  = 1'b0;
   endtask

   task automatic set_pkt(input logic [31:0] d0, input logic [3:0] k0,
                          input logic [31:0] d1, input logic [3:0] k1,
                          input logic [31:0] d2, input logic [3:0] k2, input int n);
      pkt_data.delete();
      pkt_keep.delete();
      pkt_data.push_back(d0); pkt_keep.push_back(k0);
      if (n > 1) begin pkt_data.push_back(d1); pkt_keep.push_back(k1); end
      if (n > 2) begin pkt_data.push_back(d2); pkt_keep.push_back(k2); end
   endtask

   task automatic set_random_pkt(input int nbeats);
      pkt_data.delete();
      pkt_keep.delete();
      for (int i = 0; i < nbeats; i++) begin
         pkt_data.push_back($urandom);
         pkt_keep.push_back(4'($urandom));
      end
   endtask

   task automatic wait_drain();
      int waited;
      waited = 0;
      while (exp_hdr.size() != 0 || exp_pay.size() != 0) begin
         @(negedge clk);
         waited++;
         if (waited > 2000) begin
            report_fail("drain_timeout", exp_hdr.size() + exp_pay.size(), 0);
            finish_test();
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_en) begin
            ready_out    = ($urandom_range(0, 3) != 0);
            ready_header = 1'($urandom);
         end
      end
   end

   initial begin : monitor
      beat_t b;
      forever begin
         @(negedge clk);
         if (rstn) begin
            if (valid_header && ready_header) begin
               if (exp_hdr.size() == 0) begin
                  report_fail("hdr_unexpected", 1, 0);
               end else begin
                  b = exp_hdr.pop_front();
                  check("hdr_data", data_header, b.data);
                  check("hdr_keep", 32'(keep_header), 32'(b.keep));
               end
            end
            if (valid_out && ready_out) begin
               if (exp_pay.size() == 0) begin
                  report_fail("pay_unexpected", 1, 0);
               end else begin
                  b = exp_pay.pop_front();
                  check("pay_data", data_out, b.data);
                  check("pay_keep", 32'(keep_out), 32'(b.keep));
                  check("pay_last", 32'(last_out), 32'(b.last));
               end
            end
`ifdef AXIS_EXTRACT_ERR_EN
            if (err_short) err_seen++;
`endif
         end
      end
   end

   initial begin
      rstn            = 1'b0;
      valid_in        = 1'b0;
      data_in         = '0;
      keep_in         = '0;
      last_in         = 1'b0;
      byte_remove_cnt = '0;
      ready_header    = 1'b1;
      ready_out       = 1'b1;
      #23;
      check("rst_valid_header", 32'(valid_header), 0);
      check("rst_data_header", data_header, 0);
      check("rst_keep_header", 32'(keep_header), 0);
      check("rst_valid_out", 32'(valid_out), 0);
      check("rst_last_out", 32'(last_out), 0);
      check("rst_ready_in", 32'(ready_in), 1);
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;

      // cnt=1, last beat 1100: exactly fills the final output beat
      set_pkt(32'hAABBCCDD, 4'hF, 32'h11223344, 4'hF, 32'h55667788, 4'hC, 3);
      send_packet(1);
      wait_drain();

      // cnt=1, last beat 1110: spills one byte into FLUSH, held off by ready_out
      set_pkt(32'hAABBCCDD, 4'hF, 32'h11223344, 4'hF, 32'h55667700, 4'hE, 3);
      send_packet(1);
      ready_out = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("flush_ready_in", 32'(ready_in), 0);
         check("flush_valid_out", 32'(valid_out), 1);
         check("flush_data_hold", data_out, 32'h77000000);
      end
      @(posedge clk);
      #1;
      ready_out = 1'b1;
      wait_drain();

      // cnt=3: whole first beat is header, no FLUSH afterwards
      set_pkt(32'h01020304, 4'hF, 32'h05000000, 4'h8, 0, 0, 2);
      send_packet(3);
      @(negedge clk);
      check("h4_no_flush", 32'(valid_out), 0);
      wait_drain();

      // cnt=2, single short beat: truncated header and no payload
      set_pkt(32'hDEADBEEF, 4'hC, 0, 0, 0, 0, 1);
      send_packet(2);
      wait_drain();

      // header held 20 cycles across two back-to-back packets
      ready_header = 1'b0;
      fork
         begin
            set_pkt(32'hA0A1A2A3, 4'hF, 32'hA4A5A6A7, 4'hE, 0, 0, 2);
            send_packet(0);
            set_pkt(32'h0A0B0C0D, 4'hF, 32'h0E0F1011, 4'hF, 0, 0, 2);
            send_packet(2);
         end
         begin
            repeat (20) @(negedge clk);
            check("stall_ready_in", 32'(ready_in), 0);
            check("stall_pay_left", 32'(exp_pay.size()), 2);
            check("stall_hdr_left", 32'(exp_hdr.size()), 2);
            @(posedge clk);
            #1;
            ready_header = 1'b1;
         end
      join
      wait_drain();

      // random packets with random back-pressure and input gaps
      rand_en = 1'b1;
      gap_en  = 1'b1;
      for (int p = 0; p < 40; p++) begin
         set_random_pkt($urandom_range(1, 4));
         send_packet($urandom_range(0, 3));
      end
      wait_drain();

      // reset in the middle of STREAM, then a clean packet
      set_random_pkt(5);
      push_expected(1);
      byte_remove_cnt = 2'd1;
      drive_beat(pkt_data[0], 4'hF, 1'b0);
      drive_beat(pkt_data[1], 4'hF, 1'b0);
      valid_in = 1'b1;
      data_in  = pkt_data[2];
      #2;
      rstn = 1'b0;
      #1;
      check("midrst_valid_out", 32'(valid_out), 0);
      check("midrst_valid_header", 32'(valid_header), 0);
      check("midrst_last_out", 32'(last_out), 0);
      check("midrst_data_header", data_header, 0);
      exp_hdr.delete();
      exp_pay.delete();
      valid_in = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;
      for (int p = 0; p < 6; p++) begin
         set_random_pkt($urandom_range(1, 4));
         send_packet($urandom_range(0, 3));
      end
      wait_drain();

`ifdef AXIS_EXTRACT_ERR_EN
      check("err_short_count", 32'(err_seen), 32'(err_exp));
`endif
      finish_test();
   end

endmodule
